// File: rtl/fila_pkg.sv
// rtl/fila_pkg.sv - shared constants and reader state encoding for the fila byte queue
`timescale 1ns/1ps
package fila_pkg;

    localparam int DATA_W     = 8;
    localparam int LEN_W      = 8;
    localparam int FILA_DEPTH = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PULSE   = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        GAP     = 3'd4
    } leitor_state_t;

endpackage

// File: rtl/fila_gap_counter.sv
// rtl/fila_gap_counter.sv - loadable down-counter with zero flag for pacing between pops
`timescale 1ns/1ps
module fila_gap_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load takes priority over decrement; the counter never wraps below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fila_leitor.sv
// rtl/fila_leitor.sv - consumer-side controller that drains fila and hands bytes downstream
`timescale 1ns/1ps
module fila_leitor #(
    parameter int DATA_W     = fila_pkg::DATA_W,
    parameter int LEN_W      = fila_pkg::LEN_W,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk_10KHz,
    input  logic              reset,
    input  logic              enable_in,
    input  logic [LEN_W-1:0]  len_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              dequeue_out,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [CNT_W-1:0]  count_out,
    output logic              busy_out
);

    import fila_pkg::*;

    // A zero-cycle gap still needs a 1-bit counter so the instance stays legal.
    localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam bit HAS_GAP  = (GAP_CYCLES > 0);

    leitor_state_t state;
    leitor_state_t state_next;
    logic          handshake;
    logic          gap_load;
    logic          gap_dec;
    logic          gap_zero;

    assign handshake = (state == HOLD) && ready_in;

    fila_gap_counter #(
        .W(GAP_W)
    ) u_gap (
        .clk      (clk_10KHz),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_W'(GAP_LOAD)),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    // State register; reset abandons any word in flight without reissuing a pop.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: the pop decision is taken only in IDLE, later len_in changes are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_in && (len_in != '0)) state_next = PULSE;
            PULSE:   state_next = CAPTURE;
            CAPTURE: state_next = HOLD;
            HOLD:    if (ready_in) state_next = HAS_GAP ? GAP : IDLE;
            GAP:     if (gap_zero) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded purely from the registered state.
    always_comb begin
        dequeue_out = (state == PULSE);
        valid_out   = (state == HOLD);
        busy_out    = (state != IDLE);
        gap_load    = handshake && HAS_GAP;
        gap_dec     = (state == GAP) && !gap_zero;
    end

    // Capture the popped word the cycle after the dequeue pulse, then hold it.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            data_out <= '0;
        end else if (state == CAPTURE) begin
            data_out <= data_in;
        end
    end

    // Delivered-word counter, free-running wrap.
    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            count_out <= '0;
        end else if (handshake) begin
            count_out <= count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_fila_leitor.sv
// tb/tb_fila_leitor.sv - directed bench for fila_leitor against a behavioural fila
`timescale 1ns/1ps
module tb_fila_leitor;

    logic clk = 1'b0;
    always #50000 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Instance A: no pacing gap
    logic        reset_a, enable_a, ready_a;
    logic [7:0]  len_a, data_a;
    logic [7:0]  fd_a = 8'h00;
    logic        deq_a, valid_a, busy_a;
    logic [15:0] count_a;
    logic [7:0]  mem_a [0:255];
    logic [7:0]  wr_a = 8'd0;
    logic [7:0]  rd_a = 8'd0;
    logic [7:0]  got_a [$];
    int          pulses_a [$];

    // Instance B: GAP_CYCLES = 3
    logic        reset_b, enable_b, ready_b;
    logic [7:0]  len_b, data_b;
    logic [7:0]  fd_b = 8'h00;
    logic        deq_b, valid_b, busy_b;
    logic [15:0] count_b;
    logic [7:0]  mem_b [0:255];
    logic [7:0]  wr_b = 8'd0;
    logic [7:0]  rd_b = 8'd0;
    logic [7:0]  got_b [$];
    int          pulses_b [$];

    assign len_a = wr_a - rd_a;
    assign len_b = wr_b - rd_b;

    fila_leitor #(.GAP_CYCLES(0)) dut_a (
        .clk_10KHz(clk), .reset(reset_a), .enable_in(enable_a), .len_in(len_a),
        .data_in(fd_a), .dequeue_out(deq_a), .data_out(data_a), .valid_out(valid_a),
        .ready_in(ready_a), .count_out(count_a), .busy_out(busy_a)
    );

    fila_leitor #(.GAP_CYCLES(3)) dut_b (
        .clk_10KHz(clk), .reset(reset_b), .enable_in(enable_b), .len_in(len_b),
        .data_in(fd_b), .dequeue_out(deq_b), .data_out(data_b), .valid_out(valid_b),
        .ready_in(ready_b), .count_out(count_b), .busy_out(busy_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural fila: pop on an edge with dequeue and len>0, word visible next cycle
    always @(posedge clk) begin
        if (deq_a && len_a != 8'd0) begin
            fd_a <= mem_a[rd_a];
            rd_a <= rd_a + 8'd1;
        end
        if (deq_b && len_b != 8'd0) begin
            fd_b <= mem_b[rd_b];
            rd_b <= rd_b + 8'd1;
        end
    end

    // Monitors: record delivered words and the cycle of every dequeue pulse
    always @(posedge clk) begin
        if (valid_a && ready_a) got_a.push_back(data_a);
        if (deq_a) pulses_a.push_back(cyc);
        if (valid_b && ready_b) got_b.push_back(data_b);
        if (deq_b) pulses_b.push_back(cyc);
    end

    task automatic push_a(input logic [7:0] v);
        mem_a[wr_a] = v;
        wr_a = wr_a + 8'd1;
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b] = v;
        wr_b = wr_b + 8'd1;
    endtask

    task automatic pulse_reset_a();
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        got_a.delete();
        pulses_a.delete();
    endtask

    task automatic test_reset();
        reset_a = 1'b1; enable_a = 1'b0; ready_a = 1'b0;
        reset_b = 1'b1; enable_b = 1'b0; ready_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (deq_a !== 1'b0) begin errors++; $display("FAIL reset_dequeue got %b want 0", deq_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_a); end
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b want 0", busy_b); end
        reset_a = 1'b0;
        reset_b = 1'b0;
        got_a.delete(); pulses_a.delete(); got_b.delete(); pulses_b.delete();
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        int c0;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        ready_a = 1'b1;
        enable_a = 1'b1;
        c0 = cyc;
        repeat (20) @(negedge clk);
        checks++; if (got_a.size() != 3) begin errors++; $display("FAIL basic_words got %0d want 3", got_a.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got_a.size() || got_a[i] !== exp[i]) begin
                errors++; $display("FAIL basic_data[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (pulses_a.size() != 3) begin errors++; $display("FAIL basic_pulses got %0d want 3", pulses_a.size()); end
        if (pulses_a.size() == 3) begin
            checks++; if (pulses_a[0] != c0 + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", pulses_a[0], c0 + 1); end
            checks++; if (pulses_a[1] - pulses_a[0] != 4) begin errors++; $display("FAIL basic_spacing0 got %0d want 4", pulses_a[1] - pulses_a[0]); end
            checks++; if (pulses_a[2] - pulses_a[1] != 4) begin errors++; $display("FAIL basic_spacing1 got %0d want 4", pulses_a[2] - pulses_a[1]); end
        end
        checks++; if (count_a !== 16'd3) begin errors++; $display("FAIL basic_count got %0d want 3", count_a); end
        checks++; if (len_a !== 8'd0) begin errors++; $display("FAIL basic_len got %0d want 0", len_a); end
        checks++; if (deq_a !== 1'b0) begin errors++; $display("FAIL basic_deq_idle got %b want 0", deq_a); end
    endtask

    task automatic test_backpressure();
        enable_a = 1'b0;
        pulse_reset_a();
        ready_a = 1'b0;
        for (int i = 1; i <= 8; i++) push_a(8'(i * 8'h11));
        enable_a = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 8'h11) begin errors++; $display("FAIL bp_data got %h want 11", data_a); end
        checks++; if (len_a !== 8'd7) begin errors++; $display("FAIL bp_len got %0d want 7", len_a); end
        checks++; if (pulses_a.size() != 1) begin errors++; $display("FAIL bp_pulses got %0d want 1", pulses_a.size()); end
        ready_a = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (got_a.size() != 8) begin errors++; $display("FAIL bp_words got %0d want 8", got_a.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got_a.size() || got_a[i] !== 8'((i + 1) * 8'h11)) begin
                errors++; $display("FAIL bp_data[%0d] got %h want %h", i, (i < got_a.size()) ? got_a[i] : 8'hxx, 8'((i + 1) * 8'h11));
            end
        end
        checks++; if (count_a !== 16'd8) begin errors++; $display("FAIL bp_count got %0d want 8", count_a); end
        checks++; if (len_a !== 8'd0) begin errors++; $display("FAIL bp_len_end got %0d want 0", len_a); end
    endtask

    task automatic test_empty();
        int n_deq = 0, n_valid = 0, n_busy = 0;
        enable_a = 1'b1;
        ready_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (deq_a !== 1'b0) n_deq++;
            if (valid_a !== 1'b0) n_valid++;
            if (busy_a !== 1'b0) n_busy++;
        end
        checks++; if (n_deq != 0) begin errors++; $display("FAIL empty_deq cycles_high %0d want 0", n_deq); end
        checks++; if (n_valid != 0) begin errors++; $display("FAIL empty_valid cycles_high %0d want 0", n_valid); end
        checks++; if (n_busy != 0) begin errors++; $display("FAIL empty_busy cycles_high %0d want 0", n_busy); end
    endtask

    task automatic test_gap();
        push_b(8'hA1); push_b(8'hB2); push_b(8'hC3);
        ready_b = 1'b1;
        enable_b = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (pulses_b.size() != 3) begin errors++; $display("FAIL gap_pulses got %0d want 3", pulses_b.size()); end
        if (pulses_b.size() == 3) begin
            checks++; if (pulses_b[1] - pulses_b[0] != 7) begin errors++; $display("FAIL gap_spacing0 got %0d want 7", pulses_b[1] - pulses_b[0]); end
            checks++; if (pulses_b[2] - pulses_b[1] != 7) begin errors++; $display("FAIL gap_spacing1 got %0d want 7", pulses_b[2] - pulses_b[1]); end
        end
        checks++;
        if (got_b.size() != 3 || got_b[0] !== 8'hA1 || got_b[1] !== 8'hB2 || got_b[2] !== 8'hC3) begin
            errors++; $display("FAIL gap_data got %0d words want A1 B2 C3", got_b.size());
        end
        checks++; if (count_b !== 16'd3) begin errors++; $display("FAIL gap_count got %0d want 3", count_b); end
    endtask

    task automatic test_reset_mid();
        int n;
        enable_a = 1'b0;
        pulse_reset_a();
        ready_a = 1'b0;
        push_a(8'h11); push_a(8'h22); push_a(8'h33);
        enable_a = 1'b1;
        n = 0;
        while (!(valid_a === 1'b1 && data_a === 8'h11) && n < 20) begin @(negedge clk); n++; end
        checks++; if (!(valid_a === 1'b1 && data_a === 8'h11)) begin errors++; $display("FAIL mid_wait11 got %h want 11", data_a); end
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        n = 0;
        while (!(valid_a === 1'b1 && data_a === 8'h22) && n < 20) begin @(negedge clk); n++; end
        checks++; if (!(valid_a === 1'b1 && data_a === 8'h22)) begin errors++; $display("FAIL mid_wait22 got %h want 22", data_a); end
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid_a); end
        checks++; if (count_a !== 16'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy_a); end
        got_a.delete();
        ready_a = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 8'h33) begin
            errors++; $display("FAIL mid_resume got %0d words first %h want 1 word 33", got_a.size(), (got_a.size() > 0) ? got_a[0] : 8'hxx);
        end
        checks++; if (count_a !== 16'd1) begin errors++; $display("FAIL mid_count_end got %0d want 1", count_a); end
        checks++; if (len_a !== 8'd0) begin errors++; $display("FAIL mid_len got %0d want 0", len_a); end
    endtask

    task automatic test_enable_drop();
        int n;
        got_a.delete();
        pulses_a.delete();
        ready_a = 1'b1;
        enable_a = 1'b1;
        push_a(8'h44); push_a(8'h55);
        n = 0;
        while (deq_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (deq_a !== 1'b1) begin errors++; $display("FAIL en_wait_pulse got %b want 1", deq_a); end
        enable_a = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (got_a.size() != 1 || got_a[0] !== 8'h44) begin
            errors++; $display("FAIL en_current got %0d words first %h want 1 word 44", got_a.size(), (got_a.size() > 0) ? got_a[0] : 8'hxx);
        end
        checks++; if (pulses_a.size() != 1) begin errors++; $display("FAIL en_pulses got %0d want 1", pulses_a.size()); end
        checks++; if (len_a !== 8'd1) begin errors++; $display("FAIL en_len got %0d want 1", len_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL en_busy got %b want 0", busy_a); end
        enable_a = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (got_a.size() != 2 || got_a[1] !== 8'h55) begin
            errors++; $display("FAIL en_resume got %0d words want 2 ending 55", got_a.size());
        end
        checks++; if (len_a !== 8'd0) begin errors++; $display("FAIL en_len_end got %0d want 0", len_a); end
    endtask

    initial begin
        reset_a = 1'b1; enable_a = 1'b0; ready_a = 1'b0;
        reset_b = 1'b1; enable_b = 1'b0; ready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_gap();
        test_reset_mid();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
